fork_navigator: RTL and testbench

- Route sequencer directly downstream of the line-tracker fork detector.
- Consumes the registered 1-bit fork flag, debounces it and counts forks along a preloaded route.
- At each confirmed fork, issues a timed turn command: straight, left, right or stop.
- Feeds the motor-drive mux. It does not drive motor PWM itself.

---
 rtl/fork_navigator.sv | 182 ++++++++++++++++++
 tb/tb_fork_navigator.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_navigator.sv
// Route sequencer fed by the fork detector: debounces detect_fork, walks an 8-entry route
// and issues timed turn commands. Optional watchdog on FOLLOW: define FORK_TIMEOUT_EN.
module fork_navigator #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int TURN_CYC     = 25000000,
    parameter int COOL_CYC     = 12500000,
    parameter int CNT_W        = 26,
    parameter int TIMEOUT_CYC  = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        detect_fork,
    input  logic [15:0] route,
    output logic [1:0]  drive_cmd,
    output logic [2:0]  fork_idx,
    output logic        busy,
    output logic        done
`ifdef FORK_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FOLLOW,
        S_CONFIRM,
        S_TURN,
        S_COOL,
        S_FINISH
    } state_t;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_FWD  = 2'b01;
    localparam logic [1:0] CMD_L    = 2'b10;
    localparam logic [1:0] CMD_R    = 2'b11;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYC - 1);
    localparam bit               DEB_ONE   = (DEBOUNCE_CYC == 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       entry;
    logic             confirm;

`ifdef FORK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic tmo_q, tmo_d;
`endif

    assign entry = route[{idx_q, 1'b0} +: 2];

    // The FOLLOW sample is the first of the DEBOUNCE_CYC high samples, so CONFIRM starts at 1.
    assign confirm = detect_fork &&
                     ((state_q == S_FOLLOW && DEB_ONE) ||
                      (state_q == S_CONFIRM && cnt_q == DEB_LAST));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        cmd_d   = cmd_q;
`ifdef FORK_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            cmd_d   = CMD_STOP;
`ifdef FORK_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
        end else if (confirm) begin
            cnt_d = '0;
            case (entry)
                2'b00:   begin state_d = S_COOL;   cmd_d = CMD_FWD;  end
                2'b01:   begin state_d = S_TURN;   cmd_d = CMD_L;    end
                2'b10:   begin state_d = S_TURN;   cmd_d = CMD_R;    end
                default: begin state_d = S_FINISH; cmd_d = CMD_STOP; end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FOLLOW;
                    cnt_d   = '0;
                    cmd_d   = CMD_FWD;
                end
                S_FOLLOW: begin
                    if (detect_fork) begin
                        state_d = S_CONFIRM;
                        cnt_d   = CNT_W'(1);
                    end
`ifdef FORK_TIMEOUT_EN
                    else if (cnt_q == TMO_LAST) begin
                        state_d = S_FINISH;
                        cnt_d   = '0;
                        cmd_d   = CMD_STOP;
                        tmo_d   = 1'b1;
                    end
`else
                    else begin
                        cnt_d = '0;
                    end
`endif
                end
                S_CONFIRM: begin
                    if (!detect_fork) begin
                        state_d = S_FOLLOW;
                        cnt_d   = '0;
                    end
                end
                S_TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        state_d = S_COOL;
                        cnt_d   = '0;
                        cmd_d   = CMD_FWD;
                    end
                end
                S_COOL: begin
                    if (cnt_q == COOL_LAST) begin
                        cnt_d = '0;
                        if (idx_q == 3'd7) begin
                            state_d = S_FINISH;
                            cmd_d   = CMD_STOP;
                        end else begin
                            state_d = S_FOLLOW;
                            idx_d   = idx_q + 3'd1;
                        end
                    end
                end
                S_FINISH: cnt_d = '0;
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    cmd_d   = CMD_STOP;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cmd_q   <= CMD_STOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef FORK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= 1'b0;
        else        tmo_q <= tmo_d;
    end
    assign timeout_err = tmo_q;
`endif

    assign drive_cmd = cmd_q;
    assign fork_idx  = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fork_navigator.sv
// Bench for fork_navigator: table vectors, hand-written route sequences and a random run
// compared against a countdown-style reference model.
module tb_fork_navigator;

    localparam int DEB  = 4;
    localparam int TURN = 10;
    localparam int COOL = 8;
    localparam int TMO  = 20;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_FWD  = 2'b01;
    localparam logic [1:0] CMD_L    = 2'b10;
    localparam logic [1:0] CMD_R    = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        detect_fork = 1'b0;
    logic [15:0] route = 16'h0000;
    logic [1:0]  drive_cmd;
    logic [2:0]  fork_idx;
    logic        busy;
    logic        done;
`ifdef FORK_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fork_navigator #(
        .DEBOUNCE_CYC(DEB),
        .TURN_CYC    (TURN),
        .COOL_CYC    (COOL),
        .CNT_W       (26),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .detect_fork(detect_fork),
        .route      (route),
        .drive_cmd  (drive_cmd),
        .fork_idx   (fork_idx),
        .busy       (busy),
        .done       (done)
`ifdef FORK_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    // ---------------- reference model ----------------
    // Remaining-cycle countdowns and a run length of consecutive high samples.
    bit         m_active, m_fin;
    int         m_idx, m_run, m_turn, m_cool;
    logic [1:0] m_cmd;
`ifdef FORK_TIMEOUT_EN
    bit         m_tmo;
    int         m_wait;
`endif

    task automatic model_clear();
        m_active = 0; m_fin = 0; m_idx = 0; m_run = 0; m_turn = 0; m_cool = 0;
        m_cmd = CMD_STOP;
`ifdef FORK_TIMEOUT_EN
        m_tmo = 0; m_wait = 0;
`endif
    endtask

    task automatic model_finish();
        m_fin = 1;
        m_cmd = CMD_STOP;
    endtask

    task automatic model_step(input logic en, input logic det, input logic [15:0] rt);
        logic [1:0] e;
        if (!en) begin
            model_clear();
            return;
        end
        if (m_fin) return;
        if (!m_active) begin
            m_active = 1; m_run = 0; m_cmd = CMD_FWD;
`ifdef FORK_TIMEOUT_EN
            m_wait = 0;
`endif
            return;
        end
        if (m_turn > 0) begin
            m_turn--;
            if (m_turn == 0) begin
                m_cool = COOL;
                m_cmd  = CMD_FWD;
            end
            return;
        end
        if (m_cool > 0) begin
            m_cool--;
            if (m_cool == 0) begin
                if (m_idx == 7) model_finish();
                else begin
                    m_idx++;
                    m_run = 0;
`ifdef FORK_TIMEOUT_EN
                    m_wait = 0;
`endif
                end
            end
            return;
        end
        if (det) begin
            m_run++;
            if (m_run == DEB) begin
                m_run = 0;
                e = rt[2*m_idx +: 2];
                case (e)
                    2'd0: m_cool = COOL;
                    2'd1: begin m_turn = TURN; m_cmd = CMD_L; end
                    2'd2: begin m_turn = TURN; m_cmd = CMD_R; end
                    default: model_finish();
                endcase
            end
        end else if (m_run > 0) begin
            m_run = 0;
`ifdef FORK_TIMEOUT_EN
            m_wait = 0;
`endif
        end
`ifdef FORK_TIMEOUT_EN
        else begin
            m_wait++;
            if (m_wait == TMO) begin
                model_finish();
                m_tmo = 1;
            end
        end
`endif
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model();
        check("drive_cmd", 32'(drive_cmd), 32'(m_cmd));
        check("fork_idx", 32'(fork_idx), 32'(m_idx));
        check("busy", 32'(busy), 32'(m_active && !m_fin));
        check("done", 32'(done), 32'(m_fin));
`ifdef FORK_TIMEOUT_EN
        check("timeout_err", 32'(timeout_err), 32'(m_tmo));
`endif
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic en, input logic det, input logic [15:0] rt);
        enable = en;
        detect_fork = det;
        route = rt;
        @(posedge clk);
        model_step(en, det, rt);
        #1;
    endtask

    // One fork pulse of DEB high samples followed by `tail` low samples; counts turn cycles.
    task automatic fork_pulse(input logic [15:0] rt, input int tail, output int n_l, output int n_r);
        n_l = 0; n_r = 0;
        for (int i = 0; i < DEB + tail; i++) begin
            step(1'b1, i < DEB, rt);
            check_model();
            if (drive_cmd == CMD_L) n_l++;
            if (drive_cmd == CMD_R) n_r++;
        end
    endtask

    typedef struct {
        logic       en;
        logic       det;
        logic [1:0] cmd;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[9];
    logic [6:0] exp_q[$];

    initial begin
        int n_l, n_r;
        int run_left;
        logic det_r, en_r;
        logic [15:0] rt_r;
        logic [6:0] got, want;

        // idle, then a 3-cycle glitch that must not confirm
        tbl[0] = '{1'b0, 1'b0, CMD_STOP, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, CMD_FWD,  3'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, CMD_FWD,  3'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, CMD_FWD,  3'd0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, CMD_FWD,  3'd0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, CMD_FWD,  3'd0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, CMD_FWD,  3'd0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, CMD_FWD,  3'd0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, CMD_STOP, 3'd0, 1'b0, 1'b0};

        model_clear();
        #1;
        check("reset drive_cmd", 32'(drive_cmd), 32'(CMD_STOP));
        check("reset fork_idx", 32'(fork_idx), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].en, tbl[i].det, 16'h0002);
            check($sformatf("vec%0d drive_cmd", i), 32'(drive_cmd), 32'(tbl[i].cmd));
            check($sformatf("vec%0d fork_idx", i), 32'(fork_idx), 32'(tbl[i].idx));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].done));
        end

        // route run: straight, left, right, stop
        step(1'b1, 1'b0, 16'h00E4);
        check_model();
        fork_pulse(16'h00E4, 20, n_l, n_r);
        check("fork0 turns", 32'(n_l + n_r), 0);
        check("fork0 idx", 32'(fork_idx), 1);
        fork_pulse(16'h00E4, 20, n_l, n_r);
        check("fork1 turn_l len", 32'(n_l), 10);
        check("fork1 turn_r len", 32'(n_r), 0);
        fork_pulse(16'h00E4, 20, n_l, n_r);
        check("fork2 turn_r len", 32'(n_r), 10);
        check("fork2 turn_l len", 32'(n_l), 0);
        fork_pulse(16'h00E4, 3, n_l, n_r);
        check("fork3 drive_cmd", 32'(drive_cmd), 32'(CMD_STOP));
        check("fork3 done", 32'(done), 1);
        check("fork3 idx", 32'(fork_idx), 3);

        // cooldown mask: detect held high through the turn and cooldown
        step(1'b0, 1'b0, 16'h0001);
        step(1'b1, 1'b0, 16'h0001);
        for (int i = 0; i < DEB + TURN + COOL; i++) begin
            step(1'b1, 1'b1, 16'h0001);
            check_model();
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 16'h0001);
            check_model();
        end
        check("mask idx", 32'(fork_idx), 1);
        check("mask drive_cmd", 32'(drive_cmd), 32'(CMD_FWD));
        fork_pulse(16'h0001, 10, n_l, n_r);
        check("mask second fork idx", 32'(fork_idx), 2);

        // eight straight forks end in FINISH at index 7
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 8; k++) fork_pulse(16'h0000, 10, n_l, n_r);
        check("wrap done", 32'(done), 1);
        check("wrap idx", 32'(fork_idx), 7);
        check("wrap drive_cmd", 32'(drive_cmd), 32'(CMD_STOP));

        // abort during cooldown
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        fork_pulse(16'h0000, 10, n_l, n_r);
        fork_pulse(16'h0000, 2, n_l, n_r);
        step(1'b0, 1'b0, 16'h0000);
        check("abort drive_cmd", 32'(drive_cmd), 32'(CMD_STOP));
        check("abort idx", 32'(fork_idx), 0);
        check("abort busy", 32'(busy), 0);

        // asynchronous reset in the middle of a turn
        step(1'b1, 1'b0, 16'h0002);
        fork_pulse(16'h0002, 3, n_l, n_r);
        check("pre-reset turn_r", 32'(drive_cmd), 32'(CMD_R));
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check("async rst drive_cmd", 32'(drive_cmd), 32'(CMD_STOP));
        check("async rst busy", 32'(busy), 0);
        check("async rst idx", 32'(fork_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0002);
            check("post-reset idle drive_cmd", 32'(drive_cmd), 32'(CMD_STOP));
        end

`ifdef FORK_TIMEOUT_EN
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < TMO - 1; i++) step(1'b1, 1'b0, 16'h0000);
        check("timeout not early", 32'(timeout_err), 0);
        step(1'b1, 1'b0, 16'h0000);
        check("timeout_err", 32'(timeout_err), 1);
        check("timeout done", 32'(done), 1);
        step(1'b0, 1'b0, 16'h0000);
        check("timeout clear", 32'(timeout_err), 0);
`endif

        // randomized run against the model through an expected queue
        run_left = 0;
        det_r = 1'b0;
        en_r = 1'b1;
        rt_r = 16'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                det_r = ~det_r;
                run_left = det_r ? $urandom_range(1, 7) : $urandom_range(1, 14);
            end
            run_left--;
            if ($urandom_range(0, 99) == 0) en_r = 1'b0;
            else if (!en_r && $urandom_range(0, 2) == 0) en_r = 1'b1;
            if ($urandom_range(0, 19) == 0) rt_r = 16'($urandom);
            step(en_r, det_r, rt_r);
            exp_q.push_back({m_cmd, 3'(m_idx), m_active && !m_fin, m_fin});
            want = exp_q.pop_front();
            got = {drive_cmd, fork_idx, busy, done};
            check("random outputs", 32'(got), 32'(want));
`ifdef FORK_TIMEOUT_EN
            check("random timeout_err", 32'(timeout_err), 32'(m_tmo));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
